// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock period meter.
// The state enum and size bounds live here so that the sub-module and the top
// agree on them.
package clk_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } meter_state_e;

    // Default width of the period/high-time counters
    localparam int CNT_WIDTH_DEFAULT = 16;

    // Synchroniser depth: default and legal range
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;

endpackage : clk_meter_pkg

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a single edge-detect register.
// Rise/fall are reported SYNC_STAGES+1 cycles after the asynchronous
// transition. The latency is fixed, so edge-to-edge intervals are preserved.
// An out-of-range depth is clamped to the legal range.
module sync_edge_detect
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                            SYNC_STAGES;

    logic [STAGES-1:0] sync_d;
    logic [STAGES-1:0] sync_q;
    logic              prev_d;
    logic              prev_q;

    // Shift the async input through the chain; remember the last synced level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and edge-detect registers
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule : sync_edge_detect

// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous periodic signal in
// clk_in cycles. Results leave through a valid/ready handshake. Timeout and
// overrun are reported as sticky flags that clear when enable drops.
// Optional feature: define PERIOD_MINMAX_EN to add min/max period tracking.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 sig_in,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] high_out,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 timeout_out,
    output logic                 overrun_out
`ifdef PERIOD_MINMAX_EN
    ,
    output logic [CNT_WIDTH-1:0] min_period_out,
    output logic [CNT_WIDTH-1:0] max_period_out
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 rise;
    logic                 fall;
    logic                 sync_level_unused;

    meter_state_e         state_d,     state_q;
    logic [CNT_WIDTH-1:0] cnt_d,       cnt_q;
    logic [CNT_WIDTH-1:0] high_cap_d,  high_cap_q;
    logic                 high_seen_d, high_seen_q;
    logic                 timeout_d,   timeout_q;
    logic [CNT_WIDTH-1:0] period_d,    period_q;
    logic [CNT_WIDTH-1:0] high_d,      high_q;
    logic                 valid_d,     valid_q;
    logic                 overrun_d,   overrun_q;

    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] res_period;
    logic [CNT_WIDTH-1:0] res_high;
    logic                 new_result;

    // The level output is not needed here; only the edges drive the FSM.
    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .async_in (sig_in),
        .sync_out (sync_level_unused),
        .rise     (rise),
        .fall     (fall)
    );

    // counter+1 saturates, so a capture taken at the limit never wraps to zero
    assign cnt_inc    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_WIDTH'(1);
    assign res_period = cnt_inc;
    assign res_high   = high_seen_q ? high_cap_q : res_period;

    // FSM: arm on the first rise, then every rise closes one period and opens the next
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_cap_d  = high_cap_q;
        high_seen_d = high_seen_q;
        timeout_d   = timeout_q;
        new_result  = 1'b0;
        if (!enable) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            high_seen_d = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    cnt_d = '0;
                    if (rise) begin
                        high_cap_d  = '0;
                        high_seen_d = 1'b0;
                        state_d     = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        new_result  = 1'b1;
                        cnt_d       = '0;
                        high_cap_d  = '0;
                        high_seen_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_inc;
                        if (fall) begin
                            high_cap_d  = cnt_inc;
                            high_seen_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Result handshake: load when the slot is free or is being emptied, else flag overrun
    always_comb begin
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (new_result) begin
            if (!valid_q || result_ready) begin
                period_d = res_period;
                high_d   = res_high;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (result_ready) begin
            valid_d = 1'b0;
        end
        if (!enable) begin
            overrun_d = 1'b0;
        end
    end

    // State, counter and result registers
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            high_cap_q  <= '0;
            high_seen_q <= 1'b0;
            timeout_q   <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_cap_q  <= high_cap_d;
            high_seen_q <= high_seen_d;
            timeout_q   <= timeout_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign period_out   = period_q;
    assign high_out     = high_q;
    assign result_valid = valid_q;
    assign timeout_out  = timeout_q;
    assign overrun_out  = overrun_q;

`ifdef PERIOD_MINMAX_EN
    logic [CNT_WIDTH-1:0] min_d, min_q;
    logic [CNT_WIDTH-1:0] max_d, max_q;

    // Track extremes over every produced result, including ones dropped by overrun
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (!enable) begin
            min_d = '1;
            max_d = '0;
        end else if (new_result) begin
            if (res_period < min_q) min_d = res_period;
            if (res_period > max_q) max_d = res_period;
        end
    end

    // Min/max period registers
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_period_out = min_q;
    assign max_period_out = max_q;
`endif

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter. A timestamp-based reference model
// predicts every output each cycle; directed phases add literal expectations.
// With PERIOD_MINMAX_EN defined, the min/max outputs are checked as well.
module tb_clk_period_meter;

    localparam int CW   = 6;
    localparam int SS   = 3;
    localparam int MAXV = (1 << CW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_MEAS = 2;

    logic          clk_in = 1'b0;
    logic          reset_n;
    logic          sig_in;
    logic          enable;
    logic          result_ready;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          result_valid;
    logic          timeout_out;
    logic          overrun_out;
`ifdef PERIOD_MINMAX_EN
    logic [CW-1:0] min_period_out;
    logic [CW-1:0] max_period_out;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;
    int rdy_mode = 0;

    // Reference model state: timestamps rather than counters
    int hist[$];
    int t_now, t_start, t_fall;
    int m_mode;
    int m_period, m_high, m_valid, m_timeout, m_overrun, m_min, m_max;

    clk_period_meter #(
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .sig_in         (sig_in),
        .enable         (enable),
        .period_out     (period_out),
        .high_out       (high_out),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .timeout_out    (timeout_out),
        .overrun_out    (overrun_out)
`ifdef PERIOD_MINMAX_EN
        ,
        .min_period_out (min_period_out),
        .max_period_out (max_period_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back(0);
        t_now = 0; t_start = 0; t_fall = -1;
        m_mode = M_IDLE;
        m_period = 0; m_high = 0; m_valid = 0; m_timeout = 0; m_overrun = 0;
        m_min = MAXV; m_max = 0;
    endfunction

    function automatic void model_step();
        int  rise_seen, fall_seen, elapsed, p, h;
        bit  produced;
        // Edges become visible SS+1 samples after they reach sig_in
        rise_seen = (hist[SS-1] == 1 && hist[SS] == 0) ? 1 : 0;
        fall_seen = (hist[SS-1] == 0 && hist[SS] == 1) ? 1 : 0;
        hist.push_front(int'(sig_in));
        void'(hist.pop_back());
        t_now++;
        produced = 1'b0;
        p = 0; h = 0;
        if (!enable) begin
            m_mode = M_IDLE; m_timeout = 0; m_overrun = 0; m_min = MAXV; m_max = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARM;
        end else if (m_mode == M_ARM) begin
            if (rise_seen != 0) begin
                m_mode = M_MEAS; t_start = t_now; t_fall = -1;
            end
        end else begin
            elapsed = t_now - t_start;
            if (rise_seen != 0) begin
                p = (elapsed > MAXV) ? MAXV : elapsed;
                h = (t_fall >= 0) ? (t_fall - t_start) : p;
                produced = 1'b1;
                t_start = t_now; t_fall = -1;
            end else if (elapsed == MAXV + 1) begin
                m_timeout = 1; m_mode = M_ARM;
            end else if (fall_seen != 0) begin
                t_fall = t_now;
            end
        end
        if (produced) begin
            if (p < m_min) m_min = p;
            if (p > m_max) m_max = p;
            if (m_valid == 0 || result_ready) begin
                m_period = p; m_high = h; m_valid = 1;
            end else begin
                m_overrun = 1;
            end
        end else if (result_ready) begin
            m_valid = 0;
        end
    endfunction

    // Model advances on the same edges as the DUT, including async reset
    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk_in) begin
        if (cmp_on) begin
            check_output("period_out", int'(period_out), m_period);
            check_output("high_out", int'(high_out), m_high);
            check_output("result_valid", int'(result_valid), m_valid);
            check_output("timeout_out", int'(timeout_out), m_timeout);
            check_output("overrun_out", int'(overrun_out), m_overrun);
`ifdef PERIOD_MINMAX_EN
            check_output("min_period_out", int'(min_period_out), m_min);
            check_output("max_period_out", int'(max_period_out), m_max);
`endif
        end
    end

    task automatic apply_stimulus(input logic s, input logic en);
        @(posedge clk_in);
        #1;
        sig_in = s;
        enable = en;
        case (rdy_mode)
            0:       result_ready = 1'b0;
            1:       result_ready = 1'b1;
            default: result_ready = logic'($urandom_range(0, 1));
        endcase
    endtask

    task automatic hold(input logic s, input logic en, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(s, en);
    endtask

    task automatic run_wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            hold(1'b1, 1'b1, h);
            hold(1'b0, 1'b1, l);
        end
    endtask

    initial begin
        int r, p, h;
        reset_n = 1'b0; sig_in = 1'b0; enable = 1'b0; result_ready = 1'b0;
        @(posedge clk_in);
        #1;
        cmp_on = 1'b1;
        check_output("reset_period", int'(period_out), 0);
        check_output("reset_valid", int'(result_valid), 0);
        check_output("reset_timeout", int'(timeout_out), 0);
        hold(1'b0, 1'b0, 2);
        reset_n = 1'b1;

        // Period 8 / high 4 with the consumer stalled: first result held, overrun raised
        rdy_mode = 0;
        hold(1'b0, 1'b1, 4);
        run_wave(4, 4, 5);
        hold(1'b0, 1'b1, 2);
        #2;
        check_output("lit_p8_period", int'(period_out), 8);
        check_output("lit_p8_high", int'(high_out), 4);
        check_output("lit_p8_valid", int'(result_valid), 1);
        check_output("lit_p8_overrun", int'(overrun_out), 1);
        rdy_mode = 1;
        apply_stimulus(1'b0, 1'b1);
        rdy_mode = 0;
        run_wave(4, 4, 2);

        // Disable clears flags, ready drains the pending result
        rdy_mode = 1;
        hold(1'b0, 1'b0, 3);
        #2;
        check_output("lit_dis_valid", int'(result_valid), 0);
        check_output("lit_dis_overrun", int'(overrun_out), 0);

        // Asymmetric duty: high 3, low 7
        rdy_mode = 0;
        hold(1'b0, 1'b1, 3);
        run_wave(3, 7, 4);
        #2;
        check_output("lit_asym_period", int'(period_out), 10);
        check_output("lit_asym_high", int'(high_out), 3);

        // Timeout: one rise, then static high long enough to saturate
        rdy_mode = 1;
        hold(1'b1, 1'b1, MAXV + 12);
        #2;
        check_output("lit_to_flag", int'(timeout_out), 1);
        check_output("lit_to_valid", int'(result_valid), 0);
        rdy_mode = 0;
        run_wave(3, 3, 4);
        #2;
        check_output("lit_p6_period", int'(period_out), 6);
        check_output("lit_p6_high", int'(high_out), 3);
        check_output("lit_p6_timeout", int'(timeout_out), 1);

        // Drop enable mid-period: flags clear, pending result unchanged
        hold(1'b1, 1'b1, 2);
        hold(1'b1, 1'b0, 2);
        #2;
        check_output("lit_mid_timeout", int'(timeout_out), 0);
        check_output("lit_mid_valid", int'(result_valid), 1);
        check_output("lit_mid_period", int'(period_out), 6);

        // Asynchronous reset between clock edges
        hold(1'b0, 1'b1, 6);
        @(posedge clk_in);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("lit_arst_period", int'(period_out), 0);
        check_output("lit_arst_high", int'(high_out), 0);
        check_output("lit_arst_valid", int'(result_valid), 0);
        check_output("lit_arst_overrun", int'(overrun_out), 0);
        hold(1'b0, 1'b1, 2);
        reset_n = 1'b1;

        // Randomised traffic: mixed periods, duty, readiness, enable drops, timeouts
        rdy_mode = 2;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                hold(sig_in, 1'b0, $urandom_range(1, 5));
            end else if (r == 1) begin
                hold(logic'($urandom_range(0, 1)), 1'b1, MAXV + $urandom_range(3, 10));
            end else begin
                p = $urandom_range(3, 20);
                h = $urandom_range(1, p - 1);
                run_wave(h, p - h, $urandom_range(1, 4));
            end
        end

`ifdef PERIOD_MINMAX_EN
        // Min/max: reinitialised by enable low, then alternate 8 and 12
        rdy_mode = 1;
        hold(1'b0, 1'b0, 2);
        #2;
        check_output("lit_min_init", int'(min_period_out), MAXV);
        check_output("lit_max_init", int'(max_period_out), 0);
        for (int k = 0; k < 3; k++) begin
            run_wave(4, 4, 1);
            run_wave(6, 6, 1);
        end
        hold(1'b0, 1'b1, 6);
        #2;
        check_output("lit_min_8", int'(min_period_out), 8);
        check_output("lit_max_12", int'(max_period_out), 12);
        hold(1'b0, 1'b0, 2);
        #2;
        check_output("lit_min_reinit", int'(min_period_out), MAXV);
        check_output("lit_max_reinit", int'(max_period_out), 0);
`endif

        hold(1'b0, 1'b1, 4);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_clk_period_meter
